// File: rtl/alu_multicycle_if.sv
// Operand/result bundle between the datapath (master) and the multicycle ALU (slave).
// Carries the start/busy/done handshake plus operands and registered results.
interface alu_multicycle_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [3:0]       alu_control;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] result;
    logic [WIDTH-1:0] hi;
    logic             zero;
    logic             busy;
    logic             done;
    logic             div_by_zero;

    modport master (
        output start, alu_control, a, b,
        input  result, hi, zero, busy, done, div_by_zero
    );

    modport slave (
        input  start, alu_control, a, b,
        output result, hi, zero, busy, done, div_by_zero
    );
endinterface

// File: rtl/alu_multicycle.sv
// Execution unit: single-cycle ADD/SUB/SLT/AND/OR and an iterative signed
// restoring divider (quotient in result, remainder in hi) behind start/busy/done.
module alu_multicycle #(
    parameter int WIDTH = 32
) (
    input logic             clk,
    input logic             reset,
    alu_multicycle_if.slave bus
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

    typedef enum logic [3:0] {
        OP_AND = 4'b0000,
        OP_OR  = 4'b0001,
        OP_ADD = 4'b0010,
        OP_SUB = 4'b0110,
        OP_SLT = 4'b0111,
        OP_DIV = 4'b1010
    } op_t;

    state_t           state, state_n;
    logic [WIDTH-1:0] rem, rem_n;
    logic [WIDTH-1:0] quot, quot_n;
    logic [WIDTH-1:0] dvs, dvs_n;
    logic             neg_q, neg_q_n;
    logic             neg_r, neg_r_n;
    logic [CW-1:0]    cnt, cnt_n;
    logic [WIDTH-1:0] result, result_n;
    logic [WIDTH-1:0] hi, hi_n;
    logic             zero, zero_n;
    logic             done, done_n;
    logic             dbz, dbz_n;

    logic [WIDTH:0]   shifted;
    logic             ge;
    logic [WIDTH-1:0] diff;
    logic [WIDTH-1:0] a_mag, b_mag;
    logic [WIDTH-1:0] q_fix, r_fix;
    logic [WIDTH-1:0] res;
    logic [WIDTH-1:0] hi_v;
    logic             slt;

    // Magnitudes are unsigned WIDTH-bit, so |-2^(WIDTH-1)| is represented exactly.
    always_comb begin
        a_mag   = bus.a[WIDTH-1] ? -bus.a : bus.a;
        b_mag   = bus.b[WIDTH-1] ? -bus.b : bus.b;
        shifted = {rem, quot[WIDTH-1]};
        ge      = (shifted >= {1'b0, dvs});
        diff    = shifted[WIDTH-1:0] - dvs;
        q_fix   = neg_q ? -quot : quot;
        r_fix   = neg_r ? -rem : rem;
        slt     = ($signed(bus.a) < $signed(bus.b));
    end

    always_comb begin
        state_n  = state;
        rem_n    = rem;
        quot_n   = quot;
        dvs_n    = dvs;
        neg_q_n  = neg_q;
        neg_r_n  = neg_r;
        cnt_n    = cnt;
        result_n = result;
        hi_n     = hi;
        zero_n   = zero;
        dbz_n    = dbz;
        done_n   = 1'b0;
        res      = '0;
        hi_v     = '0;

        case (state)
            IDLE: begin
                if (bus.start) begin
                    dbz_n  = 1'b0;
                    done_n = 1'b1;
                    case (bus.alu_control)
                        OP_ADD: res = bus.a + bus.b;
                        OP_SUB: res = bus.a - bus.b;
                        OP_SLT: res = {{(WIDTH-1){1'b0}}, slt};
                        OP_AND: res = bus.a & bus.b;
                        OP_OR:  res = bus.a | bus.b;
                        OP_DIV: begin
                            if (bus.b == '0) begin
                                res   = '1;
                                hi_v  = bus.a;
                                dbz_n = 1'b1;
                            end else begin
                                done_n  = 1'b0;
                                quot_n  = a_mag;
                                rem_n   = '0;
                                dvs_n   = b_mag;
                                neg_q_n = bus.a[WIDTH-1] ^ bus.b[WIDTH-1];
                                neg_r_n = bus.a[WIDTH-1];
                                cnt_n   = '0;
                                state_n = RUN;
                            end
                        end
                        default: res = '0;
                    endcase
                    if (done_n) begin
                        result_n = res;
                        hi_n     = hi_v;
                        zero_n   = (res == '0);
                    end
                end
            end
            RUN: begin
                // Dividend bits shift out of quot into rem; quotient bits shift in at bit 0.
                quot_n = {quot[WIDTH-2:0], ge};
                rem_n  = ge ? diff : shifted[WIDTH-1:0];
                cnt_n  = cnt + CW'(1);
                if (cnt == CW'(WIDTH-1)) begin
                    cnt_n   = '0;
                    state_n = FIX;
                end
            end
            FIX: begin
                result_n = q_fix;
                hi_n     = r_fix;
                zero_n   = (q_fix == '0);
                done_n   = 1'b1;
                state_n  = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            rem    <= '0;
            quot   <= '0;
            dvs    <= '0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            cnt    <= '0;
            result <= '0;
            hi     <= '0;
            zero   <= 1'b0;
            done   <= 1'b0;
            dbz    <= 1'b0;
        end else begin
            state  <= state_n;
            rem    <= rem_n;
            quot   <= quot_n;
            dvs    <= dvs_n;
            neg_q  <= neg_q_n;
            neg_r  <= neg_r_n;
            cnt    <= cnt_n;
            result <= result_n;
            hi     <= hi_n;
            zero   <= zero_n;
            done   <= done_n;
            dbz    <= dbz_n;
        end
    end

    assign bus.result      = result;
    assign bus.hi          = hi;
    assign bus.zero        = zero;
    assign bus.busy        = (state != IDLE);
    assign bus.done        = done;
    assign bus.div_by_zero = dbz;
endmodule

// File: tb/tb_alu_multicycle.sv
// Directed bench for alu_multicycle: single-cycle ops, signed division,
// divide-by-zero, busy-ignore, back-to-back acceptance and mid-op reset.
module tb_alu_multicycle;
    localparam int WIDTH = 32;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;

    alu_multicycle_if #(.WIDTH(WIDTH)) bus ();

    alu_multicycle #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    // Drive one start pulse; returns 1 time unit after the accepting edge with operands scrambled.
    task automatic issue(input logic [3:0] c, input logic [31:0] x, input logic [31:0] y);
        @(negedge clk);
        bus.start       = 1'b1;
        bus.alu_control = c;
        bus.a           = x;
        bus.b           = y;
        @(posedge clk);
        #1;
        bus.start       = 1'b0;
        bus.alu_control = 4'($urandom);
        bus.a           = $urandom;
        bus.b           = $urandom;
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (bus.done !== 1'b1 && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
    endtask

    task automatic test_reset();
        #2;
        n_checks++; if (bus.result !== 32'h0) begin n_fail++; $display("FAIL reset_result: got %h expected %h", bus.result, 32'h0); end
        n_checks++; if (bus.hi !== 32'h0) begin n_fail++; $display("FAIL reset_hi: got %h expected %h", bus.hi, 32'h0); end
        n_checks++; if ({bus.zero, bus.busy, bus.done, bus.div_by_zero} !== 4'b0000) begin n_fail++; $display("FAIL reset_flags: got %b expected %b", {bus.zero, bus.busy, bus.done, bus.div_by_zero}, 4'b0000); end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_single_cycle();
        issue(4'b0010, 32'd5, 32'd7);
        n_checks++; if (bus.done !== 1'b1) begin n_fail++; $display("FAIL add_done: got %b expected 1", bus.done); end
        n_checks++; if (bus.result !== 32'd12) begin n_fail++; $display("FAIL add_result: got %h expected %h", bus.result, 32'd12); end
        n_checks++; if ({bus.zero, bus.hi} !== {1'b0, 32'h0}) begin n_fail++; $display("FAIL add_zero_hi: got %b/%h expected 0/0", bus.zero, bus.hi); end
        @(posedge clk); #1;
        n_checks++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL done_single_pulse: got %b expected 0", bus.done); end
        n_checks++; if (bus.result !== 32'd12) begin n_fail++; $display("FAIL result_hold: got %h expected %h", bus.result, 32'd12); end

        issue(4'b0110, 32'd3, 32'd3);
        n_checks++; if ({bus.result, bus.zero} !== {32'h0, 1'b1}) begin n_fail++; $display("FAIL sub_zero: got %h/%b expected 0/1", bus.result, bus.zero); end

        issue(4'b0111, 32'hFFFF_FFFF, 32'd1);
        n_checks++; if (bus.result !== 32'd1) begin n_fail++; $display("FAIL slt_neg: got %h expected %h", bus.result, 32'd1); end
        issue(4'b0111, 32'd1, 32'hFFFF_FFFF);
        n_checks++; if (bus.result !== 32'd0) begin n_fail++; $display("FAIL slt_pos: got %h expected %h", bus.result, 32'd0); end

        issue(4'b0000, 32'h0000_F0F0, 32'h0000_0FF0);
        n_checks++; if (bus.result !== 32'h0000_00F0) begin n_fail++; $display("FAIL and: got %h expected %h", bus.result, 32'h0000_00F0); end
        issue(4'b0001, 32'h0000_F0F0, 32'h0000_0FF0);
        n_checks++; if (bus.result !== 32'h0000_FFF0) begin n_fail++; $display("FAIL or: got %h expected %h", bus.result, 32'h0000_FFF0); end

        issue(4'b0011, 32'h1234_5678, 32'h1);
        n_checks++; if ({bus.done, bus.zero, bus.result} !== {1'b1, 1'b1, 32'h0}) begin n_fail++; $display("FAIL illegal: got done=%b zero=%b result=%h expected 1/1/0", bus.done, bus.zero, bus.result); end
    endtask

    task automatic test_div();
        int n;
        issue(4'b1010, 32'd100, 32'd7);
        n_checks++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL div_busy: got %b expected 1", bus.busy); end
        wait_done(n);
        n_checks++; if (n !== 33) begin n_fail++; $display("FAIL div_latency: got %0d expected 33", n); end
        n_checks++; if ({bus.result, bus.hi} !== {32'd14, 32'd2}) begin n_fail++; $display("FAIL div_100_7: got %h/%h expected %h/%h", bus.result, bus.hi, 32'd14, 32'd2); end
        n_checks++; if ({bus.busy, bus.div_by_zero} !== 2'b00) begin n_fail++; $display("FAIL div_flags: got %b expected 00", {bus.busy, bus.div_by_zero}); end

        issue(4'b1010, 32'hFFFF_FFF9, 32'd2);
        wait_done(n);
        n_checks++; if ({bus.result, bus.hi} !== {32'hFFFF_FFFD, 32'hFFFF_FFFF}) begin n_fail++; $display("FAIL div_neg7_2: got %h/%h expected FFFFFFFD/FFFFFFFF", bus.result, bus.hi); end
    endtask

    task automatic test_div_by_zero();
        int n;
        issue(4'b1010, 32'd9, 32'd0);
        n_checks++; if ({bus.done, bus.div_by_zero} !== 2'b11) begin n_fail++; $display("FAIL dbz_flags: got %b expected 11", {bus.done, bus.div_by_zero}); end
        n_checks++; if ({bus.result, bus.hi} !== {32'hFFFF_FFFF, 32'd9}) begin n_fail++; $display("FAIL dbz_values: got %h/%h expected FFFFFFFF/00000009", bus.result, bus.hi); end
        issue(4'b0010, 32'd1, 32'd1);
        n_checks++; if ({bus.div_by_zero, bus.result} !== {1'b0, 32'd2}) begin n_fail++; $display("FAIL dbz_clear: got %b/%h expected 0/2", bus.div_by_zero, bus.result); end

        issue(4'b1010, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_done(n);
        n_checks++; if ({bus.result, bus.hi, bus.div_by_zero} !== {32'h8000_0000, 32'h0, 1'b0}) begin n_fail++; $display("FAIL div_min_neg1: got %h/%h/%b expected 80000000/0/0", bus.result, bus.hi, bus.div_by_zero); end
    endtask

    task automatic test_back_to_back();
        int n;
        issue(4'b1010, 32'd100, 32'd7);
        n = 0;
        repeat (4) begin @(posedge clk); #1; n++; end
        bus.start = 1'b1; bus.alu_control = 4'b0010; bus.a = 32'd1; bus.b = 32'd1;
        @(posedge clk); #1; n++;
        bus.start = 1'b0;
        n_checks++; if ({bus.done, bus.busy} !== 2'b01) begin n_fail++; $display("FAIL busy_ignore: got done/busy=%b expected 01", {bus.done, bus.busy}); end
        while (bus.done !== 1'b1 && n < 100) begin @(posedge clk); #1; n++; end
        n_checks++; if (n !== 33) begin n_fail++; $display("FAIL ignore_latency: got %0d expected 33", n); end
        n_checks++; if ({bus.result, bus.hi} !== {32'd14, 32'd2}) begin n_fail++; $display("FAIL ignore_result: got %h/%h expected %h/%h", bus.result, bus.hi, 32'd14, 32'd2); end

        bus.start = 1'b1; bus.alu_control = 4'b0010; bus.a = 32'd20; bus.b = 32'd22;
        @(posedge clk); #1;
        bus.start = 1'b0;
        n_checks++; if ({bus.done, bus.result, bus.hi} !== {1'b1, 32'd42, 32'h0}) begin n_fail++; $display("FAIL b2b_add: got %b/%h/%h expected 1/0000002a/0", bus.done, bus.result, bus.hi); end
    endtask

    task automatic test_reset_mid_div();
        int n;
        int pulses;
        issue(4'b1010, 32'd100, 32'd7);
        repeat (10) begin @(posedge clk); #1; end
        #2;
        reset = 1'b1;
        #1;
        n_checks++; if ({bus.result, bus.hi} !== {32'h0, 32'h0}) begin n_fail++; $display("FAIL midreset_values: got %h/%h expected 0/0", bus.result, bus.hi); end
        n_checks++; if ({bus.zero, bus.busy, bus.done, bus.div_by_zero} !== 4'b0000) begin n_fail++; $display("FAIL midreset_flags: got %b expected 0000", {bus.zero, bus.busy, bus.done, bus.div_by_zero}); end
        @(negedge clk);
        reset = 1'b0;
        pulses = 0;
        repeat (40) begin @(posedge clk); #1; if (bus.done === 1'b1) pulses++; end
        n_checks++; if (pulses !== 0) begin n_fail++; $display("FAIL midreset_no_done: got %0d expected 0", pulses); end

        issue(4'b1010, 32'd50, 32'd5);
        wait_done(n);
        n_checks++; if (n !== 33) begin n_fail++; $display("FAIL post_reset_latency: got %0d expected 33", n); end
        n_checks++; if ({bus.result, bus.hi, bus.zero} !== {32'd10, 32'h0, 1'b0}) begin n_fail++; $display("FAIL div_50_5: got %h/%h/%b expected 0000000a/0/0", bus.result, bus.hi, bus.zero); end
    endtask

    initial begin
        bus.start       = 1'b0;
        bus.alu_control = 4'b0000;
        bus.a           = '0;
        bus.b           = '0;
        test_reset();
        test_single_cycle();
        test_div();
        test_div_by_zero();
        test_back_to_back();
        test_reset_mid_div();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
